// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool window sequencer.
// Holds the controller state encoding and the default feature-map size.
package pool_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_RUN  = 2'd1;
    localparam logic [1:0] ENC_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ENC_IDLE,
        S_RUN  = ENC_RUN,
        S_DONE = ENC_DONE
    } state_t;

    localparam int DEF_WIDTH_IMG  = 26;
    localparam int DEF_HEIGHT_IMG = 26;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX up counter with synchronous clear.
// The wrap output is a same-cycle strobe: it is high when an increment rolls the count back to zero.
module wrap_counter
    import pool_pkg::*;
#(
    parameter int MAX = DEF_WIDTH_IMG,
    parameter int W   = $clog2(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign wrap = inc && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/maxpool_window_ctrl.sv
// Raster sequencer for 2x2/stride-2 max pooling: gates the tap-array enable,
// applies downstream backpressure on window pixels, and frames one feature map per start.
module maxpool_window_ctrl
    import pool_pkg::*;
#(
    parameter int WIDTH_IMG  = DEF_WIDTH_IMG,
    parameter int HEIGHT_IMG = DEF_HEIGHT_IMG,
    parameter int CW         = $clog2(WIDTH_IMG),
    parameter int RW         = $clog2(HEIGHT_IMG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          out_ready,
    output logic          buf_en,
    output logic          win_valid,
    output logic [RW-1:0] pool_row,
    output logic [CW-1:0] pool_col,
    output logic          busy,
    output logic          done
);

    state_t        state;
    logic [CW-1:0] col_idx;
    logic [RW-1:0] row_idx;
    logic          col_wrap;
    logic          row_wrap;
    logic          win_cond;
    logic          accept;
    logic          clr_cnt;

    // A window closes on the odd/odd pixel; it may only be taken when the comparator can sink the result.
    assign win_cond  = row_idx[0] & col_idx[0];
    assign in_ready  = (state == S_RUN) && (out_ready || !win_cond);
    assign accept    = in_valid && in_ready;
    assign buf_en    = accept;
    assign win_valid = accept && win_cond;
    assign pool_row  = row_idx >> 1;
    assign pool_col  = col_idx >> 1;
    assign clr_cnt   = (state == S_IDLE) && start;

    wrap_counter #(
        .MAX (WIDTH_IMG),
        .W   (CW)
    ) u_col_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .clr   (clr_cnt),
        .count (col_idx),
        .wrap  (col_wrap)
    );

    wrap_counter #(
        .MAX (HEIGHT_IMG),
        .W   (RW)
    ) u_row_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (col_wrap),
        .clr   (clr_cnt),
        .count (row_idx),
        .wrap  (row_wrap)
    );

    // row_wrap fires exactly on the accept of the final pixel of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (row_wrap) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Bench for maxpool_window_ctrl: a 4x4 and a 5x3 instance, each checked every cycle
// against a raster model built from accepted-pixel counts, plus literal window/done pins.
module tb_maxpool_window_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start0, in_valid0, out_ready0;
    logic       in_ready0, buf_en0, win_valid0, busy0, done0;
    logic [1:0] pool_row0, pool_col0;

    logic       start1, in_valid1, out_ready1;
    logic       in_ready1, buf_en1, win_valid1, busy1, done1;
    logic [1:0] pool_row1;
    logic [2:0] pool_col1;

    maxpool_window_ctrl #(.WIDTH_IMG(4), .HEIGHT_IMG(4)) u4x4 (
        .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_ready(out_ready0), .buf_en(buf_en0), .win_valid(win_valid0),
        .pool_row(pool_row0), .pool_col(pool_col0), .busy(busy0), .done(done0)
    );

    maxpool_window_ctrl #(.WIDTH_IMG(5), .HEIGHT_IMG(3)) u5x3 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_ready(out_ready1), .buf_en(buf_en1), .win_valid(win_valid1),
        .pool_row(pool_row1), .pool_col(pool_col1), .busy(busy1), .done(done1)
    );

    int errors = 0;
    int checks = 0;

    // Model: frame active flag, pixels accepted so far, done expected this cycle.
    int m_act[2];
    int m_n[2];
    int m_dp[2];
    int acc_obs[2];
    int win_log0[$];
    int win_log1[$];
    int done_log0[$];
    int done_log1[$];

    function automatic void chk1(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void chki(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_step(input int k, input int w, input int h,
                              input logic st, input logic iv, input logic ordy,
                              input logic ir, input logic be, input logic wv,
                              input logic [31:0] pr, input logic [31:0] pc,
                              input logic bs, input logic dn);
        int   row, col, dp_next, entry;
        logic wc, e_ir, e_acc;
        string p;
        p = (k == 0) ? "u4x4" : "u5x3";
        if (rst) begin
            chk1({p, ".rst_in_ready"}, ir, 1'b0);
            chk1({p, ".rst_buf_en"}, be, 1'b0);
            chk1({p, ".rst_win_valid"}, wv, 1'b0);
            chk1({p, ".rst_busy"}, bs, 1'b0);
            chk1({p, ".rst_done"}, dn, 1'b0);
            m_act[k] = 0;
            m_n[k]   = 0;
            m_dp[k]  = 0;
        end else begin
            row   = m_n[k] / w;
            col   = m_n[k] % w;
            wc    = (row % 2 == 1) && (col % 2 == 1);
            e_ir  = (m_act[k] != 0) && (ordy || !wc);
            e_acc = iv && e_ir;
            chk1({p, ".in_ready"}, ir, e_ir);
            chk1({p, ".buf_en"}, be, e_acc);
            chk1({p, ".win_valid"}, wv, e_acc && wc);
            chk1({p, ".busy"}, bs, m_act[k] != 0);
            chk1({p, ".done"}, dn, m_dp[k] != 0);
            if (e_acc && wc) begin
                chki({p, ".pool_row"}, pr, 32'(row / 2));
                chki({p, ".pool_col"}, pc, 32'(col / 2));
            end
            if (wv === 1'b1) begin
                entry = (acc_obs[k] + 1) * 10000 + int'(pr) * 100 + int'(pc);
                if (k == 0) win_log0.push_back(entry);
                else        win_log1.push_back(entry);
            end
            if (dn === 1'b1) begin
                if (k == 0) done_log0.push_back(acc_obs[k]);
                else        done_log1.push_back(acc_obs[k]);
            end
            if (be === 1'b1) acc_obs[k]++;
            dp_next = 0;
            if (m_act[k] == 0 && m_dp[k] == 0) begin
                if (st) begin
                    m_act[k] = 1;
                    m_n[k]   = 0;
                end
            end else if (m_act[k] != 0 && e_acc) begin
                m_n[k]++;
                if (m_n[k] == w * h) begin
                    m_act[k] = 0;
                    m_n[k]   = 0;
                    dp_next  = 1;
                end
            end
            m_dp[k] = dp_next;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 4, 4, start0, in_valid0, out_ready0, in_ready0, buf_en0, win_valid0,
                   32'(pool_row0), 32'(pool_col0), busy0, done0);
        model_step(1, 5, 3, start1, in_valid1, out_ready1, in_ready1, buf_en1, win_valid1,
                   32'(pool_row1), 32'(pool_col1), busy1, done1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame0();
        win_log0.delete();
        done_log0.delete();
        acc_obs[0] = 0;
        start0     = 1'b1;
        in_valid0  = 1'b1;
        out_ready0 = 1'b1;
        #3;
        chk1("start_cycle_in_ready", in_ready0, 1'b0);
        chk1("start_cycle_buf_en", buf_en0, 1'b0);
        tick();
        start0 = 1'b0;
    endtask

    task automatic check_frame4(input string nm);
        int exp_log[4] = '{60000, 80001, 140100, 160101};
        chki({nm, ".done_seen"}, done_log0.size(), 1);
        chki({nm, ".win_count"}, win_log0.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < win_log0.size()) chki({nm, ".win_entry"}, win_log0[i], exp_log[i]);
        chki({nm, ".done_after"}, (done_log0.size() > 0) ? done_log0[0] : -1, 16);
        chk1({nm, ".busy_after_done"}, busy0, 1'b0);
    endtask

    // mode 0: continuous, 1: stall on pixel (1,1), 2: gapped valid, 3: random valid/ready/start
    task automatic run_frame0(input int mode, input string nm);
        int   cyc   = 0;
        int   stall = 0;
        bit   end_checked = 0;
        logic tog = 1'b1;
        begin_frame0();
        while (done_log0.size() == 0 && cyc < 500) begin
            in_valid0  = 1'b1;
            out_ready0 = 1'b1;
            start0     = 1'b0;
            if (mode == 2) begin
                in_valid0 = tog;
                tog = !tog;
            end else if (mode == 3) begin
                in_valid0  = ($urandom_range(0, 1) == 1);
                out_ready0 = ($urandom_range(0, 3) != 0);
                start0     = ($urandom_range(0, 7) == 0);
            end else if (mode == 1) begin
                if (m_n[0] == 5 && stall < 3) begin
                    out_ready0 = 1'b0;
                    stall++;
                    #3;
                    chk1("stall_in_ready", in_ready0, 1'b0);
                    chk1("stall_buf_en", buf_en0, 1'b0);
                    chki("stall_pool_row", 32'(pool_row0), 0);
                    chki("stall_pool_col", 32'(pool_col0), 0);
                end else if (stall == 3 && !end_checked) begin
                    end_checked = 1;
                    #3;
                    chk1("stall_release_win_valid", win_valid0, 1'b1);
                end
            end
            tick();
            cyc++;
        end
        start0    = 1'b0;
        in_valid0 = 1'b0;
        if (mode == 1) chki({nm, ".stall_cycles"}, stall, 3);
        check_frame4(nm);
    endtask

    task automatic run_frame1();
        int cyc = 0;
        win_log1.delete();
        done_log1.delete();
        acc_obs[1] = 0;
        start1     = 1'b1;
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        tick();
        start1 = 1'b0;
        while (done_log1.size() == 0 && cyc < 200) begin
            tick();
            cyc++;
        end
        in_valid1 = 1'b0;
        chki("f5x3.done_seen", done_log1.size(), 1);
        chki("f5x3.win_count", win_log1.size(), 2);
        if (win_log1.size() > 0) chki("f5x3.win0", win_log1[0], 70000);
        if (win_log1.size() > 1) chki("f5x3.win1", win_log1[1], 90001);
        chki("f5x3.done_after", (done_log1.size() > 0) ? done_log1[0] : -1, 15);
        chk1("f5x3.busy_after_done", busy1, 1'b0);
    endtask

    task automatic abort_test();
        int cyc = 0;
        begin_frame0();
        while (acc_obs[0] < 7 && cyc < 100) begin
            in_valid0  = 1'b1;
            out_ready0 = 1'b1;
            tick();
            cyc++;
        end
        chki("abort.accepts", acc_obs[0], 7);
        rst = 1'b1;
        #3;
        chk1("abort.in_ready", in_ready0, 1'b0);
        chk1("abort.buf_en", buf_en0, 1'b0);
        chk1("abort.win_valid", win_valid0, 1'b0);
        chk1("abort.busy", busy0, 1'b0);
        chk1("abort.done", done0, 1'b0);
        tick();
        rst       = 1'b0;
        in_valid0 = 1'b0;
        repeat (3) tick();
        chki("abort.no_done", done_log0.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_n[i] = 0; m_dp[i] = 0; acc_obs[i] = 0;
        end
        rst        = 1'b1;
        start0     = 1'b0;
        in_valid0  = 1'b1;
        out_ready0 = 1'b1;
        start1     = 1'b0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        repeat (2) tick();
        #3;
        chk1("reset.in_ready", in_ready0, 1'b0);
        chk1("reset.buf_en", buf_en0, 1'b0);
        chk1("reset.win_valid", win_valid0, 1'b0);
        chk1("reset.busy", busy0, 1'b0);
        chk1("reset.done", done0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk1("idle.in_ready_with_valid", in_ready0, 1'b0);
        in_valid0 = 1'b0;

        run_frame1();
        run_frame0(0, "continuous");
        run_frame0(1, "backpressure");
        run_frame0(2, "gapped");
        abort_test();
        run_frame0(0, "after_abort");
        for (int f = 0; f < 4; f++) run_frame0(3, "random");
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maxpool_window_ctrl.md
Name: maxpool_window_ctrl

Overview:
- Sequencer for the 2x2/stride-2 max-pooling datapath: drives the shared enable of the single-line-buffer tap array and the upstream/downstream handshakes.
- Tracks the pixel row/column of the incoming raster stream and flags the cycles in which the four taps hold a complete, stride-aligned 2x2 window.
- Sits between the convolution output stream and the max comparator. Owns frame start/done sequencing for one feature map at a time.

Parameters:
- WIDTH_IMG, 26, pixels per input row (must be >= 2).
- HEIGHT_IMG, 26, rows per input frame (must be >= 2).
- CW, $clog2(WIDTH_IMG), column counter width.
- RW, $clog2(HEIGHT_IMG), row counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  pixel accepted this cycle when in_valid && in_ready.
- out_ready  in  1  downstream (comparator/result sink) can take a pooled result.
- buf_en  out  1  enable to the tap-array DFFs/line buffer; equals the accept strobe.
- win_valid  out  1  taps plus current pixel form a complete 2x2 window this cycle.
- pool_row  out  RW  output-map row of the current window (row_idx>>1).
- pool_col  out  CW  output-map column of the current window (col_idx>>1).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last pixel of the frame is accepted.

Behaviour:
- Reset (async, rst=1): state=IDLE; col_idx=0, row_idx=0; busy=0, done=0. in_ready, buf_en and win_valid are forced to 0.
- States:
  - IDLE: start -> RUN, counters cleared.
  - RUN: if accept and col_idx==WIDTH_IMG-1 and row_idx==HEIGHT_IMG-1 -> DONE.
  - DONE: unconditional -> IDLE next cycle; done=1 only in DONE.
- start while in RUN or DONE is ignored.
- Window condition: win_cond = row_idx[0] && col_idx[0], i.e. both indices odd (0-based).
- Backpressure: in_ready = (state==RUN) && (out_ready || !win_cond). A window pixel is never accepted unless downstream can take the result.
- accept = in_valid && in_ready; buf_en = accept (combinational; the current-pixel tap is combinational).
- win_valid = accept && win_cond. pool_row/pool_col are valid whenever win_valid=1 and are otherwise don't-care but stable (driven from counters).
- Counters advance only on accept:
  - col_idx wraps WIDTH_IMG-1 -> 0 with row_idx+1.
  - row_idx wraps HEIGHT_IMG-1 -> 0 at frame end.
  - No advance while in_valid=0 or in_ready=0; taps hold because buf_en=0.
- Odd WIDTH_IMG/HEIGHT_IMG: the last column/row is consumed but produces no window (floor pooling). Output map is (WIDTH_IMG/2)x(HEIGHT_IMG/2).
- Windows per frame = floor(W/2)*floor(H/2), exactly one win_valid each.
- Stale line-buffer contents from a previous frame are harmless: the first window needs row 1, by which point the buffer holds row 0.
- Latency: 0 cycles from accepted pixel to win_valid; done is 1 cycle after the final accept.
- Reset mid-frame: immediate return to IDLE with counters cleared. The tap array is not flushed, and no done pulse is emitted.
- in_valid high in IDLE/DONE: in_ready=0, nothing consumed.

Decomposition:
- Shared package pool_pkg: state encoding (IDLE, RUN, DONE as 2-bit localparams); default image dimensions.
- One sub-module: wrap_counter (parameter MAX, inputs inc/clr, outputs count and wrap). Instantiated twice: column counter, and row counter incremented by the column wrap.

Test Plan:
- 4x4 frame, in_valid=1, out_ready=1 continuously:
  - win_valid exactly at accepts 6, 8, 14, 16 (1-based).
  - pool_(row,col) = (0,0), (0,1), (1,0), (1,1).
  - done one cycle after accept 16; busy low thereafter.
- Same frame, out_ready=0 held for 3 cycles when pixel (1,1) arrives:
  - in_ready=0 and buf_en=0 for those cycles; counters frozen.
  - Pixel accepted with win_valid=1 the cycle out_ready returns.
- Gapped input (in_valid toggling 1,0,1,0) on 4x4: same 4 windows in order; done after 16 accepts regardless of gaps.
- WIDTH_IMG=5, HEIGHT_IMG=3: exactly 2 windows at (row1,col1) and (row1,col3); column 4 and row 2 produce none; done after 15 accepts.
- Assert rst after 7 accepts: all outputs 0 same cycle. Next start gives a full 4-window frame indexed from (0,0); no done from the aborted frame.
- Pulse start during RUN: ignored, counters unaffected. start in IDLE with in_valid=1: no accept in the start cycle; first accept the cycle after.
